fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction fetch controller that sequences the byte-addressed, combinationally-read instruction memory. It owns the program counter, drives the memory address, and captures each returned word with its PC into a small FIFO. Decode consumes from that FIFO over a valid/ready handshake. It sits between `instr_mem` and the decode stage, and handles backpressure, control-flow redirects and fetch enable.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32, PC and memory address width.
- `DATA_WIDTH`, 32, instruction word width.
- `DEPTH`, 2, FIFO entries; power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; word aligned.

Ports:
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_ni` input 1: reset, asynchronous assert, active-low.
- `en_i` input 1: fetch enable; when low, no new fetches are made and PC holds.
- `redirect_i` input 1: control-flow change from execute; single-cycle pulse or level.
- `redirect_pc_i` input ADDRESS_WIDTH: redirect target.
- `imem_addr_o` output ADDRESS_WIDTH: address to instruction memory; always equals the current fetch PC.
- `imem_rd_i` input DATA_WIDTH: memory read data, valid in the same cycle as `imem_addr_o`.
- `instr_o` output DATA_WIDTH: FIFO head instruction.
- `pc_o` output ADDRESS_WIDTH: FIFO head PC.
- `valid_o` output 1: FIFO non-empty.
- `ready_i` input 1: decode accepts the head this cycle.
- `misalign_o` output 1: one-cycle pulse flagging a misaligned redirect target.
- `count_o` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- State: `fetch_pc`, FIFO storage of {pc, instr}, read/write pointers, occupancy count, and the `misalign_o` register.
- `pop` = `valid_o & ready_i`.
- `push` = `en_i & ~redirect_i & (count < DEPTH | pop)`. On push:
  - the entry {`fetch_pc`, `imem_rd_i`} is written at the write pointer;
  - `fetch_pc` ← `fetch_pc` + 4.
- Count update: push only → +1; pop only → −1; both → unchanged; both allowed when full.
- Redirect has priority over push and pop:
  - FIFO pointers and count are cleared;
  - `fetch_pc` ← {`redirect_pc_i`[ADDRESS_WIDTH-1:2], 2'b00};
  - `misalign_o` ← |`redirect_pc_i`[1:0]; it is 0 in every other cycle.
  - A pop that coincides with a redirect is honoured by decode but has no effect on state.
- PC arithmetic is modulo 2^ADDRESS_WIDTH: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Pointers are log2(DEPTH) bits and wrap naturally.
- `en_i` low: PC and fetches freeze; the FIFO still drains to decode; a redirect is still taken.
- Reset (any time, including mid-stream):
  - `fetch_pc` = RESET_PC; count = 0; pointers = 0;
  - `valid_o` = 0, `misalign_o` = 0, `count_o` = 0, `imem_addr_o` = RESET_PC;
  - `instr_o` and `pc_o` = 0 (storage cleared on reset).
- No FSM beyond the FIFO occupancy. The effective states are EMPTY (count 0), PARTIAL and FULL (count = DEPTH):
  - EMPTY→PARTIAL on push without pop;
  - FULL→PARTIAL on pop without push;
  - any state →EMPTY on redirect or reset.

## Timing
- Fetch-to-valid latency is 1 cycle: a word pushed at edge N appears on `instr_o`/`valid_o` after edge N.
- After reset release with `en_i`=1 and `ready_i`=1:
  - `valid_o` rises after the first edge;
  - one instruction is delivered per cycle thereafter.
- Redirect latency is 2 cycles:
  - redirect at edge N → `valid_o`=0 during cycle N+1, while `imem_addr_o` = target;
  - target instruction is valid after edge N+1.
- Outputs `instr_o`, `pc_o`, `valid_o`, `count_o` and `misalign_o` come from registers only.
- `imem_addr_o` is a direct register output.
- No combinational path from `ready_i` to `valid_o`. The only input→output combinational paths run through the memory, via `imem_addr_o` → `imem_rd_i`.
- When full with `ready_i`=0, `imem_addr_o` holds steady and no entry is overwritten.

## Structure
- Package `fetch_pkg`:
  - `fetch_entry_t` packed struct {pc, instr};
  - `INSTR_BYTES` = 4;
  - `RESET_PC_DEFAULT`.
- Sub-module `fetch_fifo`:
  - parameterised on DEPTH and `fetch_entry_t`;
  - ports: push/pop/flush/count/head;
  - flush has priority over push and pop.
- `fetch_ctrl` holds the PC, push logic and misalign register, and instantiates `fetch_fifo`.

## Test plan
- Reset, then `en_i`=1, `ready_i`=1, memory word = address ^ 32'hA5A5_0000 → `pc_o` sequence 0, 4, 8, 12 on consecutive cycles, each with matching `instr_o`.
- Hold `ready_i`=0 for 5 cycles from reset → `count_o` reaches 2 and `imem_addr_o` holds at 8. Then `ready_i`=1 → `pc_o` 0, 4, 8 delivered with no gap or duplicate.
- Redirect to 32'h0000_0100 while full and popping → next cycle `valid_o`=0 and `imem_addr_o`=0x100. Following cycle `pc_o`=0x100; `misalign_o` stays 0.
- Redirect to 32'h0000_0102 → `misalign_o`=1 for exactly one cycle; fetch from 0x100.
- `en_i`=0 with 2 entries queued and `ready_i`=1 → both entries drain, then `valid_o`=0 and `imem_addr_o` frozen. `en_i`=1 resumes at the frozen address.
- Assert `rst_ni` mid-stream between edges → `valid_o`, `count_o`, `misalign_o` go to 0 immediately and `imem_addr_o`=RESET_PC. Also redirect to 32'hFFFF_FFFC → next `pc_o` values are 0xFFFF_FFFC then 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// The entry struct is the default 32-bit layout; fetch_ctrl builds a width-matched one.
package fetch_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Small fetch queue of {pc, instr} entries with flush; flush wins over push and pop.
// Storage is register based so that it can be cleared by reset.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  entry_t                   wdata_i,
    output entry_t                   head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] wr_en;
    entry_t           mem_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_i && !flush_i && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) mem_q[i] <= wdata_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : fetch_fifo

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, pushes {pc, word} into the
// fetch queue, and handles backpressure, redirects and fetch enable.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic                       redirect_i,
    input  logic [ADDRESS_WIDTH-1:0]   redirect_pc_i,
    output logic [ADDRESS_WIDTH-1:0]   imem_addr_o,
    input  logic [DATA_WIDTH-1:0]      imem_rd_i,
    output logic [DATA_WIDTH-1:0]      instr_o,
    output logic [ADDRESS_WIDTH-1:0]   pc_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       misalign_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    instr;
    } entry_t;

    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                     misalign_q, misalign_d;
    logic [CNT_W-1:0]         count;
    logic                     pop;
    logic                     push;
    entry_t                   wr_entry;
    entry_t                   head;

    assign pop  = valid_o & ready_i;
    // A full queue still accepts a new word when the head leaves in the same cycle.
    assign push = en_i & ~redirect_i & ((count < CNT_W'(DEPTH)) | pop);

    assign wr_entry.pc    = fetch_pc_q;
    assign wr_entry.instr = imem_rd_i;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .wdata_i (wr_entry),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        misalign_d = 1'b0;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[ADDRESS_WIDTH-1:2], 2'b00};
            misalign_d = |redirect_pc_i[1:0];
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr_o = fetch_pc_q;
    assign instr_o     = head.instr;
    assign pc_o        = head.pc;
    assign valid_o     = (count != '0);
    assign count_o     = count;
    assign misalign_o  = misalign_q;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, async-reset sequence,
// then randomized traffic against a queue-based reference model.
module tb_fetch_ctrl;

    localparam int          DEPTH = 2;
    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rd_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        misalign_o;
    logic [1:0]  count_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign imem_rd_i = imem_addr_o ^ XMASK;

    fetch_ctrl #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .DEPTH         (DEPTH),
        .RESET_PC      (32'h0000_0000)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rd_i     (imem_rd_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .misalign_o    (misalign_o),
        .count_o       (count_o)
    );

    // Reference model: a plain queue of {pc, instr} plus the fetch address.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    bit          m_mis;

    task automatic model_reset();
        mq.delete();
        m_pc  = 32'h0;
        m_mis = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit rdy, input bit redir, input logic [31:0] rpc);
        bit pop;
        bit push;
        pop = (mq.size() != 0) && rdy;
        if (redir) begin
            mq.delete();
            m_pc  = {rpc[31:2], 2'b00};
            m_mis = (rpc[1:0] != 2'b00);
        end else begin
            m_mis = 1'b0;
            push  = en && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({m_pc, m_pc ^ XMASK});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " valid"}, {31'd0, valid_o}, {31'd0, mq.size() != 0});
        chk({tag, " count"}, {30'd0, count_o}, 32'(mq.size()));
        chk({tag, " addr"}, imem_addr_o, m_pc);
        chk({tag, " misalign"}, {31'd0, misalign_o}, {31'd0, m_mis});
        if (mq.size() != 0) begin
            chk({tag, " pc"}, pc_o, mq[0][63:32]);
            chk({tag, " instr"}, instr_o, mq[0][31:0]);
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, sample 1 time unit later.
    task automatic step(input bit en, input bit rdy, input bit redir, input logic [31:0] rpc);
        en_i          = en;
        ready_i       = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        @(posedge clk);
        model_step(en, rdy, redir, rpc);
        #1;
    endtask

    typedef struct {
        bit          en;
        bit          rdy;
        bit          redir;
        logic [31:0] rpc;
        bit          exp_valid;
        logic [1:0]  exp_count;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        bit          exp_mis;
    } vec_t;

    vec_t vecs[20];

    initial begin
        // Stall, release, redirect while full, misaligned redirect, en=0 drain, wrap.
        vecs[0]  = '{1, 0, 0, 32'h0,          1, 2'd1, 32'h0000_0004, 32'h0000_0000, 0};
        vecs[1]  = '{1, 0, 0, 32'h0,          1, 2'd2, 32'h0000_0008, 32'h0000_0000, 0};
        vecs[2]  = '{1, 0, 0, 32'h0,          1, 2'd2, 32'h0000_0008, 32'h0000_0000, 0};
        vecs[3]  = '{1, 0, 0, 32'h0,          1, 2'd2, 32'h0000_0008, 32'h0000_0000, 0};
        vecs[4]  = '{1, 0, 0, 32'h0,          1, 2'd2, 32'h0000_0008, 32'h0000_0000, 0};
        vecs[5]  = '{1, 1, 0, 32'h0,          1, 2'd2, 32'h0000_000C, 32'h0000_0004, 0};
        vecs[6]  = '{1, 1, 0, 32'h0,          1, 2'd2, 32'h0000_0010, 32'h0000_0008, 0};
        vecs[7]  = '{1, 1, 1, 32'h0000_0100,  0, 2'd0, 32'h0000_0100, 32'h0,         0};
        vecs[8]  = '{1, 1, 0, 32'h0,          1, 2'd1, 32'h0000_0104, 32'h0000_0100, 0};
        vecs[9]  = '{1, 1, 0, 32'h0,          1, 2'd1, 32'h0000_0108, 32'h0000_0104, 0};
        vecs[10] = '{1, 1, 1, 32'h0000_0102,  0, 2'd0, 32'h0000_0100, 32'h0,         1};
        vecs[11] = '{1, 1, 0, 32'h0,          1, 2'd1, 32'h0000_0104, 32'h0000_0100, 0};
        vecs[12] = '{1, 0, 0, 32'h0,          1, 2'd2, 32'h0000_0108, 32'h0000_0100, 0};
        vecs[13] = '{0, 1, 0, 32'h0,          1, 2'd1, 32'h0000_0108, 32'h0000_0104, 0};
        vecs[14] = '{0, 1, 0, 32'h0,          0, 2'd0, 32'h0000_0108, 32'h0,         0};
        vecs[15] = '{0, 1, 0, 32'h0,          0, 2'd0, 32'h0000_0108, 32'h0,         0};
        vecs[16] = '{1, 1, 0, 32'h0,          1, 2'd1, 32'h0000_010C, 32'h0000_0108, 0};
        vecs[17] = '{1, 1, 1, 32'hFFFF_FFFC,  0, 2'd0, 32'hFFFF_FFFC, 32'h0,         0};
        vecs[18] = '{1, 1, 0, 32'h0,          1, 2'd1, 32'h0000_0000, 32'hFFFF_FFFC, 0};
        vecs[19] = '{1, 1, 0, 32'h0,          1, 2'd1, 32'h0000_0004, 32'h0000_0000, 0};

        rst_ni        = 1'b0;
        en_i          = 1'b0;
        ready_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", {31'd0, valid_o}, 32'd0);
        chk("reset count", {30'd0, count_o}, 32'd0);
        chk("reset addr", imem_addr_o, 32'h0);
        chk("reset misalign", {31'd0, misalign_o}, 32'd0);
        chk("reset pc_o", pc_o, 32'h0);
        chk("reset instr_o", instr_o, 32'h0);
        #3 rst_ni = 1'b1;

        for (int i = 0; i < 20; i++) begin
            string tag;
            step(vecs[i].en, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            tag = $sformatf("vec%0d", i);
            $display("[TB] vec %0d en=%0b rdy=%0b redir=%0b rpc=%h -> valid=%0b cnt=%0d addr=%h pc=%h mis=%0b",
                     i, vecs[i].en, vecs[i].rdy, vecs[i].redir, vecs[i].rpc,
                     valid_o, count_o, imem_addr_o, pc_o, misalign_o);
            chk({tag, " valid"}, {31'd0, valid_o}, {31'd0, vecs[i].exp_valid});
            chk({tag, " count"}, {30'd0, count_o}, {30'd0, vecs[i].exp_count});
            chk({tag, " addr"}, imem_addr_o, vecs[i].exp_addr);
            chk({tag, " misalign"}, {31'd0, misalign_o}, {31'd0, vecs[i].exp_mis});
            if (vecs[i].exp_valid) begin
                chk({tag, " pc"}, pc_o, vecs[i].exp_pc);
                chk({tag, " instr"}, instr_o, vecs[i].exp_pc ^ XMASK);
            end
        end

        // Misaligned redirect, then assert reset between edges while misalign is high.
        step(1, 0, 0, 32'h0);
        step(1, 0, 1, 32'h0000_0203);
        #2 rst_ni = 1'b0;
        #1;
        $display("[TB] async reset mid-stream -> valid=%0b cnt=%0d addr=%h mis=%0b",
                 valid_o, count_o, imem_addr_o, misalign_o);
        chk("async valid", {31'd0, valid_o}, 32'd0);
        chk("async count", {30'd0, count_o}, 32'd0);
        chk("async misalign", {31'd0, misalign_o}, 32'd0);
        chk("async addr", imem_addr_o, 32'h0);
        chk("async pc_o", pc_o, 32'h0);
        model_reset();
        #2 rst_ni = 1'b1;

        // Free-running fetch after reset: pc 0, 4, 8, 12 on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 32'h0);
            $display("[TB] stream %0d pc=%h instr=%h", i, pc_o, instr_o);
            chk($sformatf("stream%0d valid", i), {31'd0, valid_o}, 32'd1);
            chk($sformatf("stream%0d pc", i), pc_o, 32'(i * 4));
            chk($sformatf("stream%0d instr", i), instr_o, 32'(i * 4) ^ XMASK);
        end

        // Randomized traffic checked against the reference model.
        for (int i = 0; i < 400; i++) begin
            bit          en;
            bit          rdy;
            bit          redir;
            logic [31:0] rpc;
            en    = ($urandom_range(0, 7) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = $urandom();
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step(en, rdy, redir, rpc);
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fetch_ctrl
